mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/risc16_pkg.sv | 12 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared widths and the arbiter state encoding for the risc16 memory path.
package risc16_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_MEM_AW = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// the port that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single combinational-read memory. Each
// access takes one ACCESS cycle followed by at least one IDLE cycle.
module mem_port_arbiter
  import risc16_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = DEF_MEM_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t state;
  logic       last;
  logic       pick_valid;
  logic       pick_winner;

  // Upper address bits alias onto the small memory and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[ADDR_W-1:MEM_AW], addr1[ADDR_W-1:MEM_AW]};

  rr_pick2 u_pick (
    .req    ({req1, req0}),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign busy = (state == ACCESS);

  // The memory-side outputs and grants are loaded on the accepting edge and
  // cleared on the way out, so they are only non-zero while in ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= ACCESS;
            last      <= pick_winner;
            gnt0      <= ~pick_winner;
            gnt1      <= pick_winner;
            mem_we    <= pick_winner ? we1 : we0;
            mem_addr  <= pick_winner ? addr1[MEM_AW-1:0] : addr0[MEM_AW-1:0];
            mem_wdata <= pick_winner ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state     <= IDLE;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          // The grant flags still identify the winner during this cycle.
          if (!mem_we) begin
            if (gnt1) begin
              rdata1  <= mem_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_rdata;
              rvalid0 <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a small
// memory and a round-robin reference model kept in the bench.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [2:0]  mem_addr;

  logic [15:0] mem [8];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge, then look at outputs 1ns later; grants and read
  // pulses must never overlap between ports.
  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
    checkOutput("rvalid_exclusive", {31'b0, rvalid0 & rvalid1}, 32'd0);
  endtask

  // Issue one request on a port, wait (bounded) for its grant, then drop req.
  task automatic applyStimulus(input int port, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata);
    int waited = 0;
    logic g;
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    do begin
      tick();
      waited++;
      g = (port == 0) ? gnt0 : gnt1;
    end while (!g && waited < 4);
    checkOutput("gnt_seen", {31'b0, g}, 32'd1);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  logic        p_req [2];
  logic        p_we [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_wdata [2];
  logic [15:0] exp_mem [8];
  logic [15:0] exp_rdata [2];
  logic        exp_last;
  int          w;
  int          e;

  task automatic drivePorts();
    req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
    req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_gnt0", {31'b0, gnt0}, 0);
    checkOutput("rst_gnt1", {31'b0, gnt1}, 0);
    checkOutput("rst_rvalid", {30'b0, rvalid1, rvalid0}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 0);
    checkOutput("rst_mem_addr", {29'b0, mem_addr}, 0);
    checkOutput("rst_mem_wdata", {16'b0, mem_wdata}, 0);
    checkOutput("rst_rdata", {rdata1, rdata0}, 0);
    rst = 1'b0;

    // Single read of entry 3 on port 0
    mem[3] = 16'hA5A5;
    applyStimulus(0, 1'b0, 16'h0003, 16'h0);
    checkOutput("rd_gnt1_low", {31'b0, gnt1}, 0);
    checkOutput("rd_mem_addr", {29'b0, mem_addr}, 3);
    checkOutput("rd_busy", {31'b0, busy}, 1);
    checkOutput("rd_mem_we", {31'b0, mem_we}, 0);
    tick();
    checkOutput("rd_rvalid0", {31'b0, rvalid0}, 1);
    checkOutput("rd_rdata0", {16'b0, rdata0}, 16'hA5A5);
    checkOutput("rd_gnt0_drop", {31'b0, gnt0}, 0);
    checkOutput("rd_busy_drop", {31'b0, busy}, 0);
    tick();
    checkOutput("rd_rvalid0_pulse", {31'b0, rvalid0}, 0);
    checkOutput("rd_rdata0_hold", {16'b0, rdata0}, 16'hA5A5);

    // Single write on port 1 with aliased address 0x000D -> entry 5
    applyStimulus(1, 1'b1, 16'h000D, 16'h1234);
    checkOutput("wr_mem_we", {31'b0, mem_we}, 1);
    checkOutput("wr_mem_addr", {29'b0, mem_addr}, 5);
    checkOutput("wr_mem_wdata", {16'b0, mem_wdata}, 16'h1234);
    tick();
    checkOutput("wr_no_rvalid1", {31'b0, rvalid1}, 0);
    checkOutput("wr_mem_we_drop", {31'b0, mem_we}, 0);
    checkOutput("wr_mem_addr_idle", {29'b0, mem_addr}, 0);
    checkOutput("wr_mem_content", {16'b0, mem[5]}, 16'h1234);
    tick();
    checkOutput("wr_no_rvalid1_late", {31'b0, rvalid1}, 0);

    // Reset in the middle of a port-0 read of 0x0009 (entry 1)
    mem[1] = 16'hBEEF;
    applyStimulus(0, 1'b0, 16'h0009, 16'h0);
    checkOutput("abort_mem_addr", {29'b0, mem_addr}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 0);
    checkOutput("abort_rvalid0", {31'b0, rvalid0}, 0);
    checkOutput("abort_rdata0", {16'b0, rdata0}, 0);
    checkOutput("abort_gnt0", {31'b0, gnt0}, 0);
    tick();
    checkOutput("abort_rvalid0_late", {31'b0, rvalid0}, 0);

    // Contention straight after reset: grants alternate 0,1,0,1 every 2 cycles
    req0 = 1; we0 = 0; addr0 = 16'h0002;
    req1 = 1; we1 = 0; addr1 = 16'h0004;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("rr_gnt0", {31'b0, gnt0}, {31'b0, (i % 2 == 0) && ((i / 2) % 2 == 0)});
      checkOutput("rr_gnt1", {31'b0, gnt1}, {31'b0, (i % 2 == 0) && ((i / 2) % 2 == 1)});
    end
    req0 = 0; req1 = 0;
    tick();
    tick();

    // Back-to-back on port 1: read entry 7, write it, read it back
    mem[7] = 16'h00FF;
    applyStimulus(1, 1'b0, 16'h0007, 16'h0);
    tick();
    checkOutput("b2b_rvalid1", {31'b0, rvalid1}, 1);
    checkOutput("b2b_rdata1", {16'b0, rdata1}, 16'h00FF);
    applyStimulus(1, 1'b1, 16'h0007, 16'h0F0F);
    checkOutput("b2b_wr_mem_we", {31'b0, mem_we}, 1);
    tick();
    applyStimulus(1, 1'b0, 16'h0007, 16'h0);
    tick();
    checkOutput("b2b_rvalid1_2", {31'b0, rvalid1}, 1);
    checkOutput("b2b_rdata1_2", {16'b0, rdata1}, 16'h0F0F);

    // Randomized traffic against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 16'($urandom);
      exp_mem[i] = mem[i];
    end
    exp_rdata[0] = 16'h0;
    exp_rdata[1] = 16'h0;
    exp_last = 1'b1;
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 0; p_we[p] = 0; p_addr[p] = 0; p_wdata[p] = 0;
    end
    for (int it = 0; it < 120; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] && $urandom_range(0, 2) != 0) begin
          p_req[p]   = 1'b1;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_addr[p]  = 16'($urandom);
          p_wdata[p] = 16'($urandom);
        end
      end
      drivePorts();
      tick();
      if (p_req[0] || p_req[1]) begin
        w = (p_req[0] && p_req[1]) ? (exp_last ? 0 : 1) : (p_req[1] ? 1 : 0);
        exp_last = (w == 1);
        e = p_addr[w] % 8;
        checkOutput("rnd_gnt0", {31'b0, gnt0}, (w == 0) ? 1 : 0);
        checkOutput("rnd_gnt1", {31'b0, gnt1}, (w == 1) ? 1 : 0);
        checkOutput("rnd_mem_we", {31'b0, mem_we}, {31'b0, p_we[w]});
        checkOutput("rnd_mem_addr", {29'b0, mem_addr}, e);
        checkOutput("rnd_mem_wdata", {16'b0, mem_wdata}, {16'b0, p_wdata[w]});
        p_req[w] = 1'b0;
        drivePorts();
        tick();
        if (p_we[w]) exp_mem[e] = p_wdata[w];
        else exp_rdata[w] = exp_mem[e];
        checkOutput("rnd_rvalid0", {31'b0, rvalid0}, (!p_we[w] && w == 0) ? 1 : 0);
        checkOutput("rnd_rvalid1", {31'b0, rvalid1}, (!p_we[w] && w == 1) ? 1 : 0);
        checkOutput("rnd_rdata0", {16'b0, rdata0}, {16'b0, exp_rdata[0]});
        checkOutput("rnd_rdata1", {16'b0, rdata1}, {16'b0, exp_rdata[1]});
      end else begin
        checkOutput("rnd_idle_busy", {31'b0, busy}, 0);
        checkOutput("rnd_idle_gnt", {30'b0, gnt1, gnt0}, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
